poly_rej_sampler: RTL and testbench
===================================

# poly_rej_sampler

Uniform rejection sampler that sits directly upstream of `polyunit_core2` and drives its DATAIN port. It consumes a 24-bit pseudorandom stream (three bytes per beat, from the Kyber-90s AES-CTR XOF) and parses each beat into two 12-bit candidates. Candidates below Q are accepted and packed four per 48-bit word. It kicks `polyunit_core2` into M_DATAIN, writes 32 words at addresses 0..31, then signals `data_in_done`.

## Interface

Parameters:
- `WID`, 12, coefficient width.
- `Q`, 3329, modulus; a candidate is accepted iff it is < Q.
- `NWORDS`, 32, words per polynomial load; address width is 5.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; ignored unless IDLE.
- `in_valid`  in  1  XOF beat valid.
- `in_ready`  out  1  sampler accepts a beat; a beat transfers when `in_valid` and `in_ready` are both high.
- `in_data`  in  24  bytes b0=[7:0], b1=[15:8], b2=[23:16].
- `mode`  out  2  to `polyunit_core2.mode`.
- `run`  out  1  to `polyunit_core2.run`.
- `data_in`  out  48  packed word to `polyunit_core2.data_in`.
- `data_in_add`  out  5  word address.
- `data_wr`  out  1  word strobe; `data_in` and `data_in_add` are valid in the same cycle.
- `data_in_done`  out  1  load-complete pulse to `polyunit_core2.data_in_done`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse to the controller.

## Operation

- FSM states: IDLE, KICK, FILL, FIN.
  - IDLE -> KICK on `start`.
  - KICK -> FILL unconditionally.
  - FILL -> FIN when word 31 is emitted.
  - FIN -> IDLE unconditionally.
- KICK: `run`=1 and `mode`=2'd2 (M_DATAIN) for exactly one cycle. In all other states `mode`=2'd0 and `run`=0.
- Parse, per accepted beat:
  - d1 = {b1[3:0], b0}
  - d2 = {b2, b1[7:4]}
- Each candidate is accepted iff it is < Q. d1 is processed before d2 in the same cycle.
- Packing:
  - Slot pointer `pos` (0..3) and word counter `wcnt` (0..31).
  - Coefficient at slot s occupies `data_in[12s+11:12s]`; slot 0 is the LSBs.
  - The j-th accepted coefficient goes to word j/4, slot j%4.
- Carry: if `pos`=3 and both candidates are accepted, d1 completes the current word and d2 lands in slot 0 of the next word. Either 0, 1 or 2 slots are filled per beat.
- Once word 31 completes, any remaining accepted candidate in that beat is discarded. `in_ready` drops and no further beats are taken.
- `in_ready`=1 only in FILL and only before the final word has been emitted.
- Arithmetic: the comparison is unsigned 12-bit; no reduction of candidates.
- Reset mid-operation: FSM returns to IDLE; `pos`, `wcnt` and the partial word are cleared; partial data is discarded.

## Timing

- Reset values: `in_ready`, `run`, `data_wr`, `data_in_done`, `busy` and `done` are 0; `mode`=0, `data_in`=0, `data_in_add`=0.
- `start` at cycle 0 -> KICK (`run`/`mode` high) at cycle 1 -> FILL at cycle 2, with `in_ready` high from cycle 2.
- A word completed by the beat at cycle t is emitted as `data_wr`=1 at cycle t+1 (registered), with `data_in_add`=`wcnt`.
- Peak throughput is 2 coefficients per cycle, so at most one word per 2 cycles. An all-accept stream needs 64 beats.
- FIN occurs the cycle after the last `data_wr`. In FIN, `data_in_done`=1 and `done`=1 for one cycle; then IDLE.
- `in_valid` low stalls the sampler with no state change. Gaps are arbitrary.
- `start` while `busy` is ignored.

## Structure

- Shared package (`poly_pkg`):
  - `WID` and `Q`.
  - Mode encodings M_NTT=0, M_INTT=1, M_DATAIN=2, M_DATAOUT=3.
  - `NWORDS`.
- One sub-module, `rej_parse`: purely combinational. It takes `in_data` and produces d1, d2, acc1 and acc2. The FSM, packer and counters live in the top.

## Test plan

- All-accept: `in_data`=24'h001001 for 64 beats. Expect exactly 32 `data_wr` pulses with addresses 0..31 and each word 48'h001001001001, then `data_in_done` and `done` 1 cycle after the last write.
- All-reject: `in_data`=24'hFFFFFF, `in_valid` held for 100 cycles. Expect no `data_wr`, `in_ready` stays 1 and `busy` stays 1.
- Boundary: `in_data`=24'hD01D00 gives d1=3328 (accepted) and d2=3329 (rejected). 128 beats -> 32 words, each 48'hD00D00D00D00.
- Carry: one beat with d1 accepted and d2 rejected (pos=1), then accept-both beats. Verify the second word's slot 0 holds the d2 carried across the word boundary. After word 31, `in_ready`=0 and the extra candidate is dropped.
- Kick and backpressure: check `run`=1 with `mode`=2 only at cycle 1 after `start`. Toggle `in_valid` randomly and expect the same word sequence as the unstalled run.
- Reset mid-load: assert `rst` after word 10. Expect all outputs at reset values the next cycle. A new `start` reloads from address 0.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial-unit front end: coefficient geometry,
// polyunit_core2 mode encodings and the sampler FSM states.
package poly_pkg;

  localparam int WID    = 12;
  localparam int Q      = 3329;
  localparam int NWORDS = 32;

  typedef enum logic [1:0] {
    M_NTT     = 2'd0,
    M_INTT    = 2'd1,
    M_DATAIN  = 2'd2,
    M_DATAOUT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KICK = 2'd1,
    S_FILL = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Slot 0 is the least-significant coefficient of a packed word.
  function automatic logic [4*WID-1:0] put_coef(input logic [4*WID-1:0] word,
                                                input logic [1:0]       slot,
                                                input logic [WID-1:0]   coef);
    logic [4*WID-1:0] r;
    r = word;
    case (slot)
      2'd0:    r[WID-1:0]         = coef;
      2'd1:    r[2*WID-1:WID]     = coef;
      2'd2:    r[3*WID-1:2*WID]   = coef;
      default: r[4*WID-1:3*WID]   = coef;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rej_parse.sv
// Splits one 24-bit XOF beat into two 12-bit candidates and flags which ones
// fall below the modulus.
module rej_parse #(
  parameter int WID = poly_pkg::WID,
  parameter int Q   = poly_pkg::Q
) (
  input  logic [23:0]    in_data,
  output logic [WID-1:0] d1,
  output logic [WID-1:0] d2,
  output logic           acc1,
  output logic           acc2
);

  localparam logic [WID-1:0] QV = WID'(Q);

  // d1 = {b1[3:0], b0}, d2 = {b2, b1[7:4]}
  assign d1   = {in_data[11:8], in_data[7:0]};
  assign d2   = {in_data[23:16], in_data[15:12]};
  assign acc1 = (d1 < QV);
  assign acc2 = (d2 < QV);

endmodule

// File: rtl/poly_rej_sampler.sv
// Rejection sampler feeding polyunit_core2: kicks it into data-in mode, then
// packs accepted coefficients four per word and writes one polynomial.
module poly_rej_sampler #(
  parameter int WID    = poly_pkg::WID,
  parameter int Q      = poly_pkg::Q,
  parameter int NWORDS = poly_pkg::NWORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [23:0]                in_data,
  output logic [1:0]                 mode,
  output logic                       run,
  output logic [4*WID-1:0]           data_in,
  output logic [$clog2(NWORDS)-1:0]  data_in_add,
  output logic                       data_wr,
  output logic                       data_in_done,
  output logic                       busy,
  output logic                       done
);

  import poly_pkg::*;

  localparam int AW = $clog2(NWORDS);
  localparam int WW = 4*WID;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS-1);

  state_t          state_q, state_d;
  logic [1:0]      pos_q, pos_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic            full_q, full_d;
  logic            data_wr_q, data_wr_d;
  logic [WW-1:0]   data_in_q, data_in_d;
  logic [AW-1:0]   data_in_add_q, data_in_add_d;

  logic [WID-1:0]  d1, d2;
  logic            acc1, acc2;
  logic            fire;

  rej_parse #(.WID(WID), .Q(Q)) u_parse (
    .in_data (in_data),
    .d1      (d1),
    .d2      (d2),
    .acc1    (acc1),
    .acc2    (acc2)
  );

  assign fire = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    wcnt_d        = wcnt_q;
    acc_d         = acc_q;
    full_d        = full_q;
    data_wr_d     = 1'b0;
    data_in_d     = data_in_q;
    data_in_add_d = data_in_add_q;

    case (state_q)
      S_IDLE: begin
        pos_d  = '0;
        wcnt_d = '0;
        acc_d  = '0;
        full_d = 1'b0;
        if (start) state_d = S_KICK;
      end
      S_KICK: state_d = S_FILL;
      S_FILL: begin
        // d1 is placed before d2; once the last word is out, leftovers are dropped.
        if (fire && acc1 && !full_d) begin
          acc_d = put_coef(acc_d, pos_d, d1);
          if (pos_d == 2'd3) begin
            data_wr_d     = 1'b1;
            data_in_d     = acc_d;
            data_in_add_d = wcnt_d;
            acc_d         = '0;
            pos_d         = 2'd0;
            if (wcnt_d == LAST_ADDR) full_d = 1'b1;
            else                     wcnt_d = wcnt_d + AW'(1);
          end else begin
            pos_d = pos_d + 2'd1;
          end
        end
        if (fire && acc2 && !full_d) begin
          acc_d = put_coef(acc_d, pos_d, d2);
          if (pos_d == 2'd3) begin
            data_wr_d     = 1'b1;
            data_in_d     = acc_d;
            data_in_add_d = wcnt_d;
            acc_d         = '0;
            pos_d         = 2'd0;
            if (wcnt_d == LAST_ADDR) full_d = 1'b1;
            else                     wcnt_d = wcnt_d + AW'(1);
          end else begin
            pos_d = pos_d + 2'd1;
          end
        end
        if (data_wr_q && (data_in_add_q == LAST_ADDR)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pos_q         <= '0;
      wcnt_q        <= '0;
      acc_q         <= '0;
      full_q        <= 1'b0;
      data_wr_q     <= 1'b0;
      data_in_q     <= '0;
      data_in_add_q <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      wcnt_q        <= wcnt_d;
      acc_q         <= acc_d;
      full_q        <= full_d;
      data_wr_q     <= data_wr_d;
      data_in_q     <= data_in_d;
      data_in_add_q <= data_in_add_d;
    end
  end

  assign in_ready     = (state_q == S_FILL) && !full_q;
  assign mode         = (state_q == S_KICK) ? M_DATAIN : M_NTT;
  assign run          = (state_q == S_KICK);
  assign busy         = (state_q != S_IDLE);
  assign data_in_done = (state_q == S_FIN);
  assign done         = (state_q == S_FIN);
  assign data_wr      = data_wr_q;
  assign data_in      = data_in_q;
  assign data_in_add  = data_in_add_q;

endmodule

// File: tb/tb_poly_rej_sampler.sv
// Self-checking bench for poly_rej_sampler: a byte-level reference model pushes
// expected words into a scoreboard that is drained on every data_wr.
module tb_poly_rej_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [1:0]  mode;
  logic        run;
  logic [47:0] data_in;
  logic [4:0]  data_in_add;
  logic        data_wr;
  logic        data_in_done;
  logic        busy;
  logic        done;

  poly_rej_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mode         (mode),
    .run          (run),
    .data_in      (data_in),
    .data_in_add  (data_in_add),
    .data_wr      (data_wr),
    .data_in_done (data_in_done),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [47:0] data;
  } word_t;

  word_t       exp_q[$];
  word_t       popped;
  int          m_pos;
  int          m_words;
  logic [47:0] m_word;
  bit          m_full;

  int          cycle = 0;
  int          last_wr_cycle = 0;
  int          wr_count = 0;
  bit          done_seen = 0;
  logic [47:0] word1_seen;

  function automatic void modelReset();
    m_pos   = 0;
    m_words = 0;
    m_word  = '0;
    m_full  = 1'b0;
    exp_q.delete();
  endfunction

  // Reference parse works on byte values, independent of bit slicing.
  function automatic void modelBeat(input logic [23:0] d);
    int c[2];
    c[0] = int'(d[7:0]) + 256 * (int'(d[15:8]) % 16);
    c[1] = 16 * int'(d[23:16]) + int'(d[15:8]) / 16;
    for (int k = 0; k < 2; k++) begin
      if (c[k] < 3329 && !m_full) begin
        m_word = m_word | (48'(c[k]) << (12 * m_pos));
        m_pos++;
        if (m_pos == 4) begin
          exp_q.push_back('{addr: 5'(m_words), data: m_word});
          m_words++;
          m_pos  = 0;
          m_word = '0;
          if (m_words == 32) m_full = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [23:0] beatData(input int kind, input int idx);
    logic [11:0] lo, hi;
    case (kind)
      0: return 24'h001001;
      1: return 24'hD01D00;
      2: begin
        if (idx == 0) return 24'hFFF123;
        lo = 12'(2 * idx);
        hi = 12'(2 * idx + 1);
        return {hi, lo};
      end
      3: return 24'($urandom);
      default: return 24'hFFFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    cycle++;
    if (data_wr === 1'b1) begin
      wr_count++;
      last_wr_cycle = cycle;
      if (data_in_add == 5'd1) word1_seen = data_in;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wr", {59'd0, data_in_add}, 64'hFFFF);
      end else begin
        popped = exp_q.pop_front();
        checkOutput("wr_addr", {59'd0, data_in_add}, {59'd0, popped.addr});
        checkOutput("wr_data", {16'd0, data_in}, {16'd0, popped.data});
      end
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      checkOutput("done_latency", 64'(cycle - last_wr_cycle), 64'd1);
      checkOutput("data_in_done", {63'd0, data_in_done}, 64'd1);
    end
  end

  task automatic resetDut();
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_outputs",
                {3'd0, in_ready, run, data_wr, data_in_done, busy, done, mode, data_in, data_in_add},
                64'd0);
    rst = 1'b0;
    modelReset();
    wr_count = 0;
  endtask

  task automatic startLoad();
    done_seen = 1'b0;
    wr_count  = 0;
    modelReset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("kick_run_mode", {60'd0, run, mode, in_ready}, {60'd0, 1'b1, 2'd2, 1'b0});
    @(negedge clk);
    checkOutput("fill_run_mode", {60'd0, run, mode, in_ready}, {60'd0, 1'b0, 2'd0, 1'b1});
  endtask

  task automatic applyStimulus(input int kind, input int stall_pct, input int stop_after);
    int beat = 0;
    int cyc  = 0;
    bit drop_checked = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stop_after > 0 && wr_count >= stop_after) break;
      in_valid = ($urandom_range(99) >= stall_pct);
      in_data  = beatData(kind, beat);
      if (m_full && !drop_checked) begin
        checkOutput("in_ready_drop", {63'd0, in_ready}, 64'd0);
        drop_checked = 1'b1;
      end
      if (in_valid && in_ready) begin
        modelBeat(in_data);
        beat++;
      end
    end
    in_valid = 1'b0;
    if (stop_after == 0) begin
      checkOutput("load_done", {63'd0, done_seen}, 64'd1);
      checkOutput("wr_count", 64'(wr_count), 64'd32);
      checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    int bad;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    modelReset();
    resetDut();

    $display("[TB] all-accept load");
    startLoad();
    applyStimulus(0, 0, 0);

    $display("[TB] boundary load");
    startLoad();
    applyStimulus(1, 0, 0);

    $display("[TB] carry load");
    word1_seen = '0;
    startLoad();
    applyStimulus(2, 0, 0);
    checkOutput("carry_word1_slot0", {52'd0, word1_seen[11:0]}, 64'd5);

    $display("[TB] backpressure load");
    startLoad();
    applyStimulus(0, 40, 0);

    $display("[TB] random data load");
    startLoad();
    applyStimulus(3, 30, 0);

    $display("[TB] all-reject");
    startLoad();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 24'hFFFFFF;
      if (in_ready !== 1'b1 || busy !== 1'b1) bad++;
      if (i == 51) checkOutput("start_ignored", {63'd0, run}, 64'd0);
      start = (i == 50);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("reject_ready_busy", 64'(bad), 64'd0);
    checkOutput("reject_no_wr", 64'(wr_count), 64'd0);
    resetDut();

    $display("[TB] reset mid-load");
    startLoad();
    applyStimulus(0, 0, 11);
    resetDut();
    startLoad();
    applyStimulus(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
